// File: rtl/noc_packet_injector.sv
// Per-node packet injector: turns (dest, len) requests plus a payload word
// stream into a wormhole flit sequence, with per-VC downstream credit tracking.
module noc_packet_injector #(
   parameter int unsigned NUM_OF_NODES            = 8,
   parameter int unsigned FLIT_DATA_WIDTH         = 16,
   parameter int unsigned NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int unsigned NODE_ID                 = 0,
   parameter int unsigned MAX_BODY_FLITS          = 4,
   parameter int unsigned CREDITS_PER_VC          = 2,
   localparam int unsigned DEST_NODE_WIDTH  = $clog2(NUM_OF_NODES),
   localparam int unsigned VC_W             = $clog2(NUM_OF_VIRTUAL_CHANNELS),
   localparam int unsigned LEN_W            = $clog2(MAX_BODY_FLITS + 1),
   localparam int unsigned FLIT_TOTAL_WIDTH = 2 + VC_W + FLIT_DATA_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               pkt_valid,
   output logic                               pkt_ready,
   input  logic [DEST_NODE_WIDTH-1:0]         pkt_dest,
   input  logic [LEN_W-1:0]                   pkt_len,
   input  logic                               pld_valid,
   output logic                               pld_ready,
   input  logic [FLIT_DATA_WIDTH-1:0]         pld_data,
   output logic [FLIT_TOTAL_WIDTH-1:0]        flit_out,
   output logic                               flit_valid,
   input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] credit_return,
   output logic                               busy,
   output logic                               credit_err
);

   localparam int unsigned CNT_W = $clog2(CREDITS_PER_VC + 1);
   localparam int unsigned PAD_W = FLIT_DATA_WIDTH - 2 * DEST_NODE_WIDTH;

   localparam logic [1:0] TYPE_HEADER = 2'b11;
   localparam logic [1:0] TYPE_HEAD   = 2'b01;
   localparam logic [1:0] TYPE_BODY   = 2'b10;
   localparam logic [1:0] TYPE_TAIL   = 2'b00;

   typedef enum logic {IDLE, PAYLOAD} state_t;

   state_t                          state_q, state_d;
   logic [VC_W-1:0]                 vc_q, vc_d;
   logic [LEN_W-1:0]                rem_q, rem_d;
   logic [FLIT_TOTAL_WIDTH-1:0]     flit_d;
   logic                            flit_valid_d;
   logic [CNT_W-1:0]                cnt_q [NUM_OF_VIRTUAL_CHANNELS];
   logic [NUM_OF_VIRTUAL_CHANNELS-1:0] sent;
   logic [VC_W-1:0]                 sel_vc;
   logic                            any_credit;
   logic [LEN_W-1:0]                len_clamped;
   logic [FLIT_DATA_WIDTH-1:0]      head_data;

   // Lowest-index VC with registered credit available
   always_comb begin
      sel_vc     = '0;
      any_credit = 1'b0;
      for (int i = NUM_OF_VIRTUAL_CHANNELS - 1; i >= 0; i--) begin
         if (cnt_q[i] != '0) begin
            sel_vc     = VC_W'(i);
            any_credit = 1'b1;
         end
      end
   end

   // Request length clamp and head-flit address field
   always_comb begin
      len_clamped = (pkt_len > LEN_W'(MAX_BODY_FLITS)) ? LEN_W'(MAX_BODY_FLITS) : pkt_len;
      head_data   = {pkt_dest, DEST_NODE_WIDTH'(NODE_ID), {PAD_W{1'b0}}};
   end

   // Next-state, handshakes and the flit to register this cycle
   always_comb begin
      state_d      = state_q;
      vc_d         = vc_q;
      rem_d        = rem_q;
      flit_d       = flit_out;
      flit_valid_d = 1'b0;
      sent         = '0;
      pkt_ready    = 1'b0;
      pld_ready    = 1'b0;
      case (state_q)
         IDLE: begin
            pkt_ready = any_credit;
            if (pkt_valid && any_credit) begin
               vc_d         = sel_vc;
               rem_d        = len_clamped;
               flit_valid_d = 1'b1;
               sent[sel_vc] = 1'b1;
               if (len_clamped == '0) begin
                  flit_d = {TYPE_HEADER, sel_vc, head_data};
               end else begin
                  flit_d  = {TYPE_HEAD, sel_vc, head_data};
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            pld_ready = (cnt_q[vc_q] != '0);
            if (pld_valid && pld_ready) begin
               flit_valid_d = 1'b1;
               sent[vc_q]   = 1'b1;
               rem_d        = rem_q - LEN_W'(1);
               if (rem_q > LEN_W'(1)) begin
                  flit_d = {TYPE_BODY, vc_q, pld_data};
               end else begin
                  flit_d  = {TYPE_TAIL, vc_q, pld_data};
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, packet context and output flit registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         vc_q       <= '0;
         rem_q      <= '0;
         flit_out   <= '0;
         flit_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         vc_q       <= vc_d;
         rem_q      <= rem_d;
         flit_out   <= flit_d;
         flit_valid <= flit_valid_d;
      end
   end

   // Per-VC credit counters; a return to a full counter is flagged, not counted
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OF_VIRTUAL_CHANNELS; i++) begin
            cnt_q[i] <= CNT_W'(CREDITS_PER_VC);
         end
         credit_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_OF_VIRTUAL_CHANNELS; i++) begin
            case ({sent[i], credit_return[i]})
               2'b10: cnt_q[i] <= cnt_q[i] - CNT_W'(1);
               2'b01: begin
                  if (cnt_q[i] == CNT_W'(CREDITS_PER_VC)) begin
                     credit_err <= 1'b1;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule
